dig_scan_driver: RTL and testbench
==================================

# dig_scan_driver

Eight-digit, time-multiplexed 7-segment display driver on the CPU data path, directly downstream of the bus bridge. It latches the 32-bit value written to the display address, with write strobe = `we_from_cpu & access_dig`. It scans the eight digits one at a time and shows each nibble as a hexadecimal glyph. Both the digit-enable and segment outputs are active-low, for common-anode displays.

## Interface
- `SCAN_DIV`, default 20000: clock cycles each digit stays lit. Legal range is ≥ 1; 1 advances the digit every cycle.
- `BLANK_LZ`, default 0: 1 enables leading-zero blanking.
- `clk_from_cpu`  in  1  system clock; one clock domain.
- `rst_from_cpu`  in  1  reset, synchronous, active-high.
- `we_dig`  in  1  write strobe for the display register.
- `wdata_dig`  in  32  display value; nibble i belongs to digit i, and digit 0 is rightmost.
- `dig_en`  out  8  digit enables, active-low, one-cold while running.
- `dig_seg`  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- `disp_value`  out  32  currently latched display value; readback/debug.

## Operation
- Value register:
  - On a rising edge with `we_dig`=1, `disp_value` <= `wdata_dig`.
  - With `we_dig`=0 the register holds, whatever `wdata_dig` carries.
- Scan counter `cnt` (width clog2(SCAN_DIV), minimum 1):
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0, and digit index `idx` (3 bits) increments; 7 wraps to 0.
- Writes never disturb `cnt` or `idx`.
- Output register, updated every cycle:
  - `dig_en` <= ~(8'b1 << idx).
  - `dig_seg` <= decode(`disp_value`[4*idx+3 : 4*idx]).
- Decode, 0–F (dp always off):
  - 0–7: C0, F9, A4, B0, 99, 92, 82, F8.
  - 8–F: 80, 90, 88, 83, C6, A1, 86, 8E.
- Blanking:
  - Applies when BLANK_LZ=1, idx≠0, and nibble idx plus all higher nibbles are 0.
  - Then `dig_seg` <= FF, while `dig_en` still selects the digit.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- No state machine beyond `cnt`/`idx`. No handshakes: the write is single-cycle and always accepted.

## Timing
- Reset values:
  - `disp_value`=0, `cnt`=0, `idx`=0.
  - `dig_en`=FF and `dig_seg`=FF, i.e. all digits dark.
  - Outputs stay FF for every edge where reset is sampled high.
- First edge after reset deasserts: `dig_en`=FE, `dig_seg`=C0.
- Latency:
  - Write sampled at edge N: `disp_value` is updated after N.
  - `dig_seg` reflects the new value after edge N+1, for the digit then selected.
- Each digit is driven for exactly SCAN_DIV consecutive cycles; a full sweep takes 8·SCAN_DIV cycles.
- Boundary cases:
  - Write on the same edge as a `cnt` wrap: both take effect. The next output uses the new `idx` and the new value.
  - Reset mid-scan: synchronous; takes precedence over write and count. The scan restarts at digit 0 with value 0.
  - SCAN_DIV=1: `idx` advances every cycle, and `dig_en` rotates FE, FD, FB, … each cycle.

## Test plan
1. Reset and first digit (SCAN_DIV=4):
   - Hold `rst_from_cpu`=1 for 3 cycles → `dig_en`=FF, `dig_seg`=FF, `disp_value`=0.
   - First edge after release → FE/C0.
2. Write 12345678, SCAN_DIV=4:
   - Two cycles later: `dig_en`=FE, `dig_seg`=80.
   - Each 4 cycles advances: FD/F8, FB/82, F7/92, EF/99, DF/B0, BF/A4, 7F/F9.
   - Then back to FE/80 exactly 32 cycles after the first FE.
3. Write DEADBEEF:
   - Digits 0..7 show 8E, 86, 86, 83, A1, 88, 86, A1.
   - Pulse `we_dig`=0 with `wdata_dig`=FFFFFFFF → `disp_value` unchanged.
4. BLANK_LZ=1:
   - Write 00000A05 → digits 0..2 seg 92, C0, 88; digits 3..7 seg FF with `dig_en` still one-cold.
   - Write 0 → digit 0 C0, all others FF.
5. Write concurrent with `cnt` wrap:
   - Write 0000000F on the edge where `idx` goes 0→1 → next output FD with seg C0 (nibble 1 = 0, BLANK_LZ=0).
   - The following digit-0 slot shows 8E.
6. Reset mid-operation:
   - Assert reset for 1 cycle while `idx`=5 → `dig_en`=FF, `dig_seg`=FF that cycle.
   - Then FE/C0, with `disp_value`=0 and the scan restarted at digit 0.

Source files
------------

// File: rtl/dig_scan_driver.sv
// Eight-digit multiplexed 7-segment driver: latches a 32-bit hex value and scans
// one nibble per digit onto active-low (common-anode) digit and segment outputs.
module dig_scan_driver #(
    parameter int SCAN_DIV = 20000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk_from_cpu,
    input  logic        rst_from_cpu,
    input  logic        we_dig,
    input  logic [31:0] wdata_dig,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg,
    output logic [31:0] disp_value
);

    localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   value_q, value_d;
    logic [7:0]    en_q, en_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    nibble;
    logic [31:0]   upper;
    logic          blank;

    // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}; dp is never lit.
    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        value_d = value_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
        if (we_dig) begin
            value_d = wdata_dig;
        end

        // Output stage looks at the pre-edge idx/value, so it lags them by one cycle.
        nibble = value_q[{idx_q, 2'b00} +: 4];
        upper  = value_q >> {idx_q, 2'b00};
        blank  = BLANK_LZ && (idx_q != 3'd0) && (upper == 32'd0);
        en_d   = ~(8'b1 << idx_q);
        seg_d  = blank ? 8'hFF : hex_glyph(nibble);
    end

    always_ff @(posedge clk_from_cpu) begin
        if (rst_from_cpu) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            value_q <= 32'd0;
            en_q    <= 8'hFF;
            seg_q   <= 8'hFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            en_q    <= en_d;
            seg_q   <= seg_d;
        end
    end

    assign dig_en     = en_q;
    assign dig_seg    = seg_q;
    assign disp_value = value_q;

endmodule

// File: tb/tb_dig_scan_driver.sv
// Directed bench: three driver instances (plain, leading-zero blanking, SCAN_DIV=1)
// share one stimulus stream; expected glyphs and cycle positions are hand-computed.
module tb_dig_scan_driver;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] wdata;

    logic [7:0]  en0, seg0, en1, seg1, en2, seg2;
    logic [31:0] val0, val1, val2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] en_tbl[8];
    logic [7:0] seg_1234[8];
    logic [7:0] seg_dead[8];
    logic [7:0] seg_a05[8];

    dig_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u0 (
        .clk_from_cpu(clk), .rst_from_cpu(rst), .we_dig(we), .wdata_dig(wdata),
        .dig_en(en0), .dig_seg(seg0), .disp_value(val0)
    );
    dig_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u1 (
        .clk_from_cpu(clk), .rst_from_cpu(rst), .we_dig(we), .wdata_dig(wdata),
        .dig_en(en1), .dig_seg(seg1), .disp_value(val1)
    );
    dig_scan_driver #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) u2 (
        .clk_from_cpu(clk), .rst_from_cpu(rst), .we_dig(we), .wdata_dig(wdata),
        .dig_en(en2), .dig_seg(seg2), .disp_value(val2)
    );

    // Clock/reset: posedges at 5,15,...; stimulus changes and sampling on negedges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        en_tbl   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        seg_1234 = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        seg_dead = '{8'h8E, 8'h86, 8'h86, 8'h83, 8'hA1, 8'h88, 8'h86, 8'hA1};
        seg_a05  = '{8'h92, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

        rst = 1'b1; we = 1'b0; wdata = 32'd0;

        // Reset held for three edges
        step(3);
        chk("rst_en",   en0,  8'hFF);
        chk("rst_seg",  seg0, 8'hFF);
        chk("rst_val",  val0, 32'd0);
        chk("rst_en_b", en1,  8'hFF);
        chk("rst_seg_b", seg1, 8'hFF);
        rst = 1'b0;

        // E1: first digit lit
        step(1);
        chk("first_en",  en0, 8'hFE);
        chk("first_seg", seg0, 8'hC0);
        chk("div1_e1_en", en2, 8'hFE);

        // Write 12345678, sampled at E2
        we = 1'b1; wdata = 32'h1234_5678;
        step(1);
        we = 1'b0;
        chk("w1_val",     val0, 32'h1234_5678);
        chk("w1_seg_old", seg0, 8'hC0);
        chk("div1_e2_en", en2, 8'hFD);
        chk("div1_e2_seg", seg2, 8'hC0);
        step(1);
        chk("w1_en_e3",  en0, 8'hFE);
        chk("w1_seg_e3", seg0, 8'h80);
        chk("w1_blz_e3", seg1, 8'h80);
        chk("div1_e3_en", en2, 8'hFB);
        chk("div1_e3_seg", seg2, 8'h82);
        step(1);
        chk("w1_seg_e4", seg0, 8'h80);
        chk("div1_e4_en", en2, 8'hF7);
        chk("div1_e4_seg", seg2, 8'h92);
        step(1);
        chk("sweep_en_d1",  en0, en_tbl[1]);
        chk("sweep_seg_d1", seg0, seg_1234[1]);
        for (int d = 2; d < 8; d++) begin
            step(4);
            chk($sformatf("sweep_en_d%0d", d),  en0, en_tbl[d]);
            chk($sformatf("sweep_seg_d%0d", d), seg0, seg_1234[d]);
        end
        step(3);
        chk("sweep_en_e32",  en0, 8'h7F);
        chk("sweep_seg_e32", seg0, 8'hF9);
        step(1);
        chk("wrap_en_e33",  en0, 8'hFE);
        chk("wrap_seg_e33", seg0, 8'h80);

        // DEADBEEF, then a non-write cycle with all-ones data
        we = 1'b1; wdata = 32'hDEAD_BEEF;
        step(1);
        we = 1'b0; wdata = 32'hFFFF_FFFF;
        chk("dead_val", val0, 32'hDEAD_BEEF);
        step(1);
        chk("hold_val", val0, 32'hDEAD_BEEF);
        step(1);
        chk("dead_en_d0",  en0, en_tbl[0]);
        chk("dead_seg_d0", seg0, seg_dead[0]);
        for (int d = 1; d < 8; d++) begin
            step(4);
            chk($sformatf("dead_en_d%0d", d),  en0, en_tbl[d]);
            chk($sformatf("dead_seg_d%0d", d), seg0, seg_dead[d]);
        end

        // Leading-zero blanking with 00000A05 (written at E65)
        we = 1'b1; wdata = 32'h0000_0A05;
        step(1);
        we = 1'b0;
        chk("blz_old_seg", seg1, 8'h8E);
        step(3);
        chk("blz_en_d0",  en1, en_tbl[0]);
        chk("blz_seg_d0", seg1, seg_a05[0]);
        for (int d = 1; d < 8; d++) begin
            step(4);
            chk($sformatf("blz_en_d%0d", d),  en1, en_tbl[d]);
            chk($sformatf("blz_seg_d%0d", d), seg1, seg_a05[d]);
            if (d == 3) chk("noblz_seg_d3", seg0, 8'hC0);
        end

        // Value zero: only digit 0 shows a glyph
        we = 1'b1; wdata = 32'd0;
        step(1);
        we = 1'b0;
        chk("zero_old_seg", seg1, 8'h92);
        step(3);
        chk("zero_en_d0",  en1, 8'hFE);
        chk("zero_seg_d0", seg1, 8'hC0);
        for (int d = 1; d < 8; d++) begin
            step(4);
            chk($sformatf("zero_en_d%0d", d),  en1, en_tbl[d]);
            chk($sformatf("zero_seg_d%0d", d), seg1, 8'hFF);
        end

        // Write on the edge where idx goes 0 -> 1 (E132)
        step(3);
        we = 1'b1; wdata = 32'h0000_000F;
        step(1);
        we = 1'b0;
        chk("cwrap_en_e132",  en0, 8'hFE);
        chk("cwrap_seg_e132", seg0, 8'hC0);
        step(1);
        chk("cwrap_en",      en0, 8'hFD);
        chk("cwrap_seg",     seg0, 8'hC0);
        chk("cwrap_blz_en",  en1, 8'hFD);
        chk("cwrap_blz_seg", seg1, 8'hFF);
        step(28);
        chk("cwrap_d0_en",  en0, 8'hFE);
        chk("cwrap_d0_seg", seg0, 8'h8E);
        chk("cwrap_val",    val0, 32'h0000_000F);

        // Reset while idx = 5 (after E180), one cycle
        step(19);
        rst = 1'b1; we = 1'b1; wdata = 32'h5555_5555;
        step(1);
        rst = 1'b0; we = 1'b0;
        chk("mrst_en",    en0, 8'hFF);
        chk("mrst_seg",   seg0, 8'hFF);
        chk("mrst_val",   val0, 32'd0);
        chk("mrst_blz_seg", seg1, 8'hFF);
        chk("mrst_div1_en", en2, 8'hFF);
        step(1);
        chk("mrst_first_en",  en0, 8'hFE);
        chk("mrst_first_seg", seg0, 8'hC0);
        chk("mrst_div1_first", en2, 8'hFE);
        step(1);
        chk("mrst_div1_next", en2, 8'hFD);
        chk("mrst_hold_en",   en0, 8'hFE);
        step(3);
        chk("mrst_d1_en",  en0, 8'hFD);
        chk("mrst_d1_seg", seg0, 8'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
